// File: rtl/ggt_binaer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : ggt_binaer_if
// Function : request/result bundle of the binary-GCD unit
// Revision : 1.0
// ----------------------------------------------------------------------------
interface ggt_binaer_if #(
   parameter int WIDTH = 16
);
   localparam int CW = $clog2(2*WIDTH+2);

   logic             start_i;
   logic [WIDTH-1:0] Zahl1_i;
   logic [WIDTH-1:0] Zahl2_i;
   logic             ready_o;
   logic             valid_o;
   logic [WIDTH-1:0] ergebnis_o;
   logic [CW-1:0]    zyklen_o;

   modport master (
      output start_i, Zahl1_i, Zahl2_i,
      input  ready_o, valid_o, ergebnis_o, zyklen_o
   );

   modport slave (
      input  start_i, Zahl1_i, Zahl2_i,
      output ready_o, valid_o, ergebnis_o, zyklen_o
   );
endinterface
`default_nettype wire

// File: rtl/ggt_binaer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : ggt_binaer
// Function : binary (Stein) GCD using shifts and subtractions only
// Revision : 1.0
// ----------------------------------------------------------------------------
module ggt_binaer #(
   parameter int WIDTH = 16
) (
   input  logic         clk,
   input  logic         rst_i,
   ggt_binaer_if.slave  bus
);
   localparam int CW = $clog2(2*WIDTH+2);
   localparam int KW = $clog2(WIDTH)+1;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_a, w_a_nxt;
   logic [WIDTH-1:0] r_b, w_b_nxt;
   logic [KW-1:0]    r_k, w_k_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic             r_valid, w_valid_nxt;
   logic [WIDTH-1:0] r_ergebnis, w_ergebnis_nxt;
   logic [CW-1:0]    r_zyklen, w_zyklen_nxt;

   always_ff @(posedge clk) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_a        <= '0;
         r_b        <= '0;
         r_k        <= '0;
         r_cnt      <= '0;
         r_valid    <= 1'b0;
         r_ergebnis <= '0;
         r_zyklen   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_a        <= w_a_nxt;
         r_b        <= w_b_nxt;
         r_k        <= w_k_nxt;
         r_cnt      <= w_cnt_nxt;
         r_valid    <= w_valid_nxt;
         r_ergebnis <= w_ergebnis_nxt;
         r_zyklen   <= w_zyklen_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_a_nxt        = r_a;
      w_b_nxt        = r_b;
      w_k_nxt        = r_k;
      w_cnt_nxt      = r_cnt;
      w_valid_nxt    = r_valid;
      w_ergebnis_nxt = r_ergebnis;
      w_zyklen_nxt   = r_zyklen;
      case (r_state)
         S_IDLE: begin
            if (bus.start_i) begin
               w_valid_nxt = 1'b0;
               w_cnt_nxt   = '0;
               // A zero operand makes the other one the answer without iterating
               if (bus.Zahl1_i == '0) begin
                  w_ergebnis_nxt = bus.Zahl2_i;
                  w_valid_nxt    = 1'b1;
                  w_zyklen_nxt   = '0;
               end else if (bus.Zahl2_i == '0) begin
                  w_ergebnis_nxt = bus.Zahl1_i;
                  w_valid_nxt    = 1'b1;
                  w_zyklen_nxt   = '0;
               end else begin
                  w_a_nxt     = bus.Zahl1_i;
                  w_b_nxt     = bus.Zahl2_i;
                  w_k_nxt     = '0;
                  w_state_nxt = S_RUN;
               end
            end
         end
         S_RUN: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_a == r_b) begin
               w_ergebnis_nxt = r_a << r_k;
               w_zyklen_nxt   = r_cnt + 1'b1;
               w_valid_nxt    = 1'b1;
               w_state_nxt    = S_IDLE;
            end else if (!r_a[0] && !r_b[0]) begin
               w_a_nxt = r_a >> 1;
               w_b_nxt = r_b >> 1;
               w_k_nxt = r_k + 1'b1;
            end else if (!r_a[0]) begin
               w_a_nxt = r_a >> 1;
            end else if (!r_b[0]) begin
               w_b_nxt = r_b >> 1;
            end else if (r_a > r_b) begin
               // Difference of two odd values is even, so halving is exact
               w_a_nxt = (r_a - r_b) >> 1;
            end else begin
               w_b_nxt = (r_b - r_a) >> 1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign bus.ready_o    = (r_state == S_IDLE);
   assign bus.valid_o    = r_valid;
   assign bus.ergebnis_o = r_ergebnis;
   assign bus.zyklen_o   = r_zyklen;
endmodule
`default_nettype wire

// File: tb/tb_ggt_binaer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_ggt_binaer
// Function : directed self-checking bench for ggt_binaer (16- and 32-bit)
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_ggt_binaer;
   logic clk;
   logic rst_i;
   int   n_total = 0;
   int   n_bad   = 0;

   ggt_binaer_if #(.WIDTH(16)) bus ();
   ggt_binaer_if #(.WIDTH(32)) bus32 ();

   ggt_binaer #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_i (rst_i),
      .bus   (bus.slave)
   );

   ggt_binaer #(.WIDTH(32)) dut32 (
      .clk   (clk),
      .rst_i (rst_i),
      .bus   (bus32.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one request on bus, then count edges until valid_o rises
   task automatic run16(input logic [15:0] a, input logic [15:0] b, output int cyc);
      bus.Zahl1_i = a;
      bus.Zahl2_i = b;
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      cyc = 0;
      while (!bus.valid_o && cyc < 40) begin
         tick();
         cyc++;
      end
   endtask

   task automatic run32(input logic [31:0] a, input logic [31:0] b, output int cyc);
      bus32.Zahl1_i = a;
      bus32.Zahl2_i = b;
      bus32.start_i = 1'b1;
      tick();
      bus32.start_i = 1'b0;
      cyc = 0;
      while (!bus32.valid_o && cyc < 80) begin
         tick();
         cyc++;
      end
   endtask

   // Expected intermediate (a, b, k) after each RUN edge of 48/18
   logic [15:0] seq_a [5] = '{16'd24, 16'd12, 16'd6, 16'd3, 16'd3};
   logic [15:0] seq_b [5] = '{16'd9,  16'd9,  16'd9, 16'd9, 16'd3};

   logic [31:0] v32_a [6] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'h0000_0000, 32'd360};
   logic [31:0] v32_b [6] = '{32'h8000_0000, 32'h0001_0000, 32'hFFFF_FFFF,
                              32'h0001_0001, 32'hDEAD_BEEF, 32'd84};
   logic [31:0] v32_g [6] = '{32'h0000_0001, 32'h0001_0000, 32'hFFFF_FFFF,
                              32'h0001_0001, 32'hDEAD_BEEF, 32'd12};

   logic [15:0] z_a [3] = '{16'd0,  16'd25, 16'd0};
   logic [15:0] z_b [3] = '{16'd25, 16'd0,  16'd0};
   logic [15:0] z_g [3] = '{16'd25, 16'd25, 16'd0};

   initial begin
      int cyc;
      rst_i         = 1'b1;
      bus.start_i   = 1'b0;
      bus.Zahl1_i   = '0;
      bus.Zahl2_i   = '0;
      bus32.start_i = 1'b0;
      bus32.Zahl1_i = '0;
      bus32.Zahl2_i = '0;
      tick();
      tick();
      rst_i = 1'b0;

      check("rst_ready", bus.ready_o, 1);
      check("rst_valid", bus.valid_o, 0);
      check("rst_erg",   bus.ergebnis_o, 0);
      check("rst_zyk",   bus.zyklen_o, 0);

      run16(16'd180, 16'd180, cyc);
      check("eq_lat",   cyc, 1);
      check("eq_erg",   bus.ergebnis_o, 180);
      check("eq_zyk",   bus.zyklen_o, 1);
      check("eq_ready", bus.ready_o, 1);

      bus.Zahl1_i = 16'd48;
      bus.Zahl2_i = 16'd18;
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      check("s_ready0", bus.ready_o, 0);
      check("s_a0", dut.r_a, 48);
      check("s_b0", dut.r_b, 18);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("s_a", dut.r_a, seq_a[i]);
         check("s_b", dut.r_b, seq_b[i]);
         check("s_k", dut.r_k, 1);
         check("s_nvalid", bus.valid_o, 0);
      end
      tick();
      check("s_valid", bus.valid_o, 1);
      check("s_erg",   bus.ergebnis_o, 6);
      check("s_zyk",   bus.zyklen_o, 6);
      check("s_ready", bus.ready_o, 1);
      bus.Zahl1_i = 16'd7;
      bus.Zahl2_i = 16'd3;
      repeat (3) tick();
      check("hold_valid", bus.valid_o, 1);
      check("hold_erg",   bus.ergebnis_o, 6);

      for (int i = 0; i < 3; i++) begin
         bus.Zahl1_i = z_a[i];
         bus.Zahl2_i = z_b[i];
         bus.start_i = 1'b1;
         tick();
         bus.start_i = 1'b0;
         check("z_valid", bus.valid_o, 1);
         check("z_erg",   bus.ergebnis_o, z_g[i]);
         check("z_zyk",   bus.zyklen_o, 0);
         check("z_ready", bus.ready_o, 1);
      end

      bus.Zahl1_i = 16'd24255;
      bus.Zahl2_i = 16'd12540;
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      cyc = 0;
      repeat (2) begin
         tick();
         cyc++;
      end
      bus.Zahl1_i = 16'd1;
      bus.Zahl2_i = 16'd65535;
      bus.start_i = 1'b1;
      tick();
      cyc++;
      bus.start_i = 1'b0;
      while (!bus.valid_o && cyc < 40) begin
         tick();
         cyc++;
      end
      check("ign_valid", bus.valid_o, 1);
      check("ign_erg",   bus.ergebnis_o, 165);
      check("ign_bound", (bus.zyklen_o <= 33), 1);
      check("ign_lat",   cyc, bus.zyklen_o);

      bus.Zahl1_i = 16'd65535;
      bus.Zahl2_i = 16'd65534;
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      repeat (2) tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check("ab_ready", bus.ready_o, 1);
      check("ab_valid", bus.valid_o, 0);
      check("ab_erg",   bus.ergebnis_o, 0);
      tick();
      check("ab_valid2", bus.valid_o, 0);
      run16(16'd12, 16'd8, cyc);
      check("ab2_erg", bus.ergebnis_o, 4);
      check("ab2_zyk", bus.zyklen_o, 5);
      check("ab2_lat", cyc, 5);

      // start_i held high: the unit must restart right after each result
      bus.Zahl1_i = 16'd6;
      bus.Zahl2_i = 16'd4;
      bus.start_i = 1'b1;
      tick();
      cyc = 0;
      while (!bus.valid_o && cyc < 40) begin
         tick();
         cyc++;
      end
      check("bb_lat",   cyc, 4);
      check("bb_erg",   bus.ergebnis_o, 2);
      check("bb_ready", bus.ready_o, 1);
      tick();
      bus.start_i = 1'b0;
      check("bb_vdrop", bus.valid_o, 0);
      check("bb_rdrop", bus.ready_o, 0);
      cyc = 0;
      while (!bus.valid_o && cyc < 40) begin
         tick();
         cyc++;
      end
      check("bb_erg2", bus.ergebnis_o, 2);

      for (int i = 0; i < 6; i++) begin
         run32(v32_a[i], v32_b[i], cyc);
         check("w32_valid", bus32.valid_o, 1);
         check("w32_erg",   bus32.ergebnis_o, v32_g[i]);
         check("w32_bound", (bus32.zyklen_o <= 65), 1);
         check("w32_lat",   cyc, bus32.zyklen_o);
         repeat (2) tick();
         check("w32_hold",  bus32.valid_o, 1);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/ggt_binaer.md
# ggt_binaer

Parametrised binary-GCD (Stein) unit; successor to the 16-bit `ggt_top`. It computes gcd(Zahl1, Zahl2) for WIDTH-bit unsigned operands using only shifts and subtractions, with no divider. It also handles zero operands, exposes a ready flag and reports the iteration count. It sits in the same slot as `ggt_top`: same start/valid style, driven by the bench or a result-capturing memory wrapper on the logic PLL clock.

## Interface
- WIDTH, 16, operand/result width in bits (≥2)
- CW, $clog2(2*WIDTH+2), width of iteration counter (derived localparam, not overridable)

- clk  in  1  single system clock, all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  request; accepted on a rising edge where start_i && ready_o
- Zahl1_i  in  WIDTH  operand A, unsigned, sampled only at acceptance
- Zahl2_i  in  WIDTH  operand B, unsigned, sampled only at acceptance
- ready_o  out  1  high when idle and able to accept start_i
- valid_o  out  1  result valid; held until next acceptance or reset
- ergebnis_o  out  WIDTH  gcd result; stable while valid_o=1
- zyklen_o  out  CW  number of RUN-state cycles used for the current result

## Operation
- States: IDLE, RUN. Internal regs a, b (WIDTH), k (shift count, $clog2(WIDTH)+1 bits), cnt (CW).
- IDLE, acceptance edge: valid_o←0, cnt←0.
  - Zahl1_i=0: ergebnis_o←Zahl2_i, valid_o←1, zyklen_o←0, stay IDLE. Covers 0,0 → 0.
  - Else if Zahl2_i=0: ergebnis_o←Zahl1_i, valid_o←1, zyklen_o←0, stay IDLE.
  - Else: a←Zahl1_i, b←Zahl2_i, k←0, go RUN, ready_o←0.
- RUN, per edge, first matching rule, cnt←cnt+1:
  - a==b: ergebnis_o←a<<k, zyklen_o←cnt+1, valid_o←1, ready_o←1, go IDLE.
  - a,b both even: a←a>>1, b←b>>1, k←k+1.
  - a even: a←a>>1.
  - b even: b←b>>1.
  - both odd, a>b: a←(a−b)>>1; else b←(b−a)>>1.
- Arithmetic is unsigned, WIDTH bits. The subtraction never underflows because of the ordering. a<<k never exceeds min(A,B), so no overflow and no extra bits.
- start_i during RUN is ignored; operands are not re-sampled.
- Zahl*_i may change freely except on the acceptance edge.

## Timing
- Reset values: ready_o=1, valid_o=0, ergebnis_o=0, zyklen_o=0; state IDLE. Internal a, b, k, cnt are don't-care.
- Reset mid-RUN aborts the computation. The next edge behaves as from reset, with no result and no valid pulse.
- Reset has priority over start_i on the same edge.
- Zero-operand latency: valid_o is high 1 cycle after the acceptance edge (visible after that edge).
- Nonzero latency: valid_o rises zyklen_o cycles after the acceptance edge. The bound is zyklen_o ≤ 2*WIDTH+1 (each step halves at least one operand).
- ready_o and valid_o rise on the same edge. A new start_i may be accepted on the very next edge; valid_o drops on that acceptance edge.
- Back-to-back use: holding start_i high continuously restarts on every edge where ready_o=1.

## Test plan
- Reset then A=180, B=180 -> valid_o at +1 cycle, ergebnis_o=180, zyklen_o=1, ready_o high again.
- A=48, B=18 -> valid_o at +6 cycles, ergebnis_o=6, zyklen_o=6. Check the intermediate sequence (24,9,k1)→(12,9)→(6,9)→(3,9)→(3,3)→done.
- Zero operands: (0,25) -> 25; (25,0) -> 25; (0,0) -> 0. Each gives valid_o at +1, zyklen_o=0, ready_o never deasserted.
- A=24255, B=12540 -> ergebnis_o=165, zyklen_o ≤ 33. Pulse start_i again with A=1, B=65535 during RUN; it must be ignored and the result must still be 165.
- Assert rst_i mid-RUN of A=65535, B=65534 -> next cycle ready_o=1, valid_o=0, ergebnis_o=0. A following A=12, B=8 yields 4.
- WIDTH=32 build, random pairs including powers of two and 0xFFFFFFFF versus a reference gcd -> all match, zyklen_o ≤ 65, valid_o held until next start.
